// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: single-outstanding load/store initiator in front of the
// word-only data_memory. Loads get byte/halfword extraction with sign or zero
// extension; sub-word stores are done as read-modify-write.
//
// Handshakes: a request transfers on a rising edge where req_valid && req_ready;
// a response transfers on a rising edge where rsp_valid && rsp_ready. Once
// raised, rsp_valid stays high with rsp_rdata/rsp_err stable until it transfers.
//
// Optional feature macro: LSU_QED_VLD_EN drives the QED commit strobe
// qed_vld_out_ex_mem from the latched req_qed_vld. When the macro is not
// defined, the strobe is tied low and req_qed_vld is ignored.
//
// Every output is a flop. Its next value is decoded from the next state, so
// each output lines up exactly with the state it belongs to.
module lsu_mem_initiator (
    input  logic        clk,
    input  logic        outside_reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_qed_vld,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] address,
    output logic [31:0] write_data,
    input  logic [31:0] read_data,
    output logic        qed_vld_out_ex_mem
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CAP  = 3'd2,
        S_WR   = 3'd3,
        S_RSP  = 3'd4
    } state_t;

    state_t      state_q, state_d;

    // Latched request fields
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;   // store data, replaced by the merged word in CAP
    logic        qed_q, qed_d;

    // Registered outputs
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic [31:0] address_q, address_d;
    logic [31:0] write_data_q, write_data_d;
    logic        qed_out_q, qed_out_d;

    // Working values for the response and for lane extraction and merging
    logic [31:0] rdata_n;
    logic        err_n;
    logic        req_bad;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_val;
    logic [31:0] merged;

    // Misalignment and illegal-size check on the incoming request
    always_comb begin
        req_bad = 1'b0;
        case (req_size)
            2'b00:   req_bad = 1'b0;
            2'b01:   req_bad = req_addr[0];
            2'b10:   req_bad = (req_addr[1:0] != 2'b00);
            default: req_bad = 1'b1;
        endcase
    end

    // Little-endian lane extraction and extension of the captured word, plus the sub-word merge
    always_comb begin
        lane_byte = read_data[{addr_q[1:0], 3'b000} +: 8];
        lane_half = addr_q[1] ? read_data[31:16] : read_data[15:0];
        load_val  = read_data;
        merged    = read_data;
        case (size_q)
            2'b00: begin
                load_val = uns_q ? {24'h0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
                merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            end
            2'b01: begin
                load_val = uns_q ? {16'h0, lane_half} : {{16{lane_half[15]}}, lane_half};
                if (addr_q[1]) merged[31:16] = wdata_q[15:0];
                else           merged[15:0]  = wdata_q[15:0];
            end
            default: begin
                load_val = read_data;
                merged   = wdata_q;
            end
        endcase
    end

    // Next-state logic, request latching, and next values of the registered outputs
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        qed_d   = qed_q;
        rdata_n = rsp_rdata_q;
        err_n   = rsp_err_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
`ifdef LSU_QED_VLD_EN
                    qed_d   = req_qed_vld;
`else
                    qed_d   = 1'b0;
`endif
                    rdata_n = 32'h0;
                    err_n   = 1'b0;
                    if (req_bad) begin
                        err_n   = 1'b1;
                        state_d = S_RSP;
                    end else if (!req_we || (req_size != 2'b10)) begin
                        state_d = S_RD;
                    end else begin
                        state_d = S_WR;
                    end
                end
            end
            S_RD: state_d = S_CAP;
            S_CAP: begin
                if (!we_q) begin
                    rdata_n = load_val;
                    err_n   = 1'b0;
                    state_d = S_RSP;
                end else begin
                    wdata_d = merged;
                    state_d = S_WR;
                end
            end
            S_WR: begin
                rdata_n = 32'h0;
                err_n   = 1'b0;
                state_d = S_RSP;
            end
            S_RSP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        req_ready_d  = (state_d == S_IDLE);
        mem_read_d   = (state_d == S_RD) || (state_d == S_CAP);
        mem_write_d  = (state_d == S_WR);
        address_d    = (mem_read_d || mem_write_d) ? {addr_d[31:2], 2'b00} : 32'h0;
        write_data_d = mem_write_d ? wdata_d : 32'h0;
        rsp_valid_d  = (state_d == S_RSP);
        rsp_rdata_d  = rsp_valid_d ? rdata_n : 32'h0;
        rsp_err_d    = rsp_valid_d & err_n;
`ifdef LSU_QED_VLD_EN
        qed_out_d    = qed_d & (((state_d == S_CAP) & ~we_d) | ((state_d == S_WR) & we_d));
`else
        qed_out_d    = 1'b0;
`endif
    end

`ifndef LSU_QED_VLD_EN
    logic unused_qed_in;
    assign unused_qed_in = req_qed_vld;
`endif

    // State, latched request, and output registers; reset drops any in-flight request
    always_ff @(posedge clk or posedge outside_reset) begin
        if (outside_reset) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            qed_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= 32'h0;
            rsp_err_q    <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            address_q    <= 32'h0;
            write_data_q <= 32'h0;
            qed_out_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            qed_q        <= qed_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            address_q    <= address_d;
            write_data_q <= write_data_d;
            qed_out_q    <= qed_out_d;
        end
    end

    assign req_ready          = req_ready_q;
    assign rsp_valid          = rsp_valid_q;
    assign rsp_rdata          = rsp_rdata_q;
    assign rsp_err            = rsp_err_q;
    assign mem_read           = mem_read_q;
    assign mem_write          = mem_write_q;
    assign address            = address_q;
    assign write_data         = write_data_q;
    assign qed_vld_out_ex_mem = qed_out_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator with a 32-word level-read memory model.
module tb_lsu_mem_initiator;

    logic        clk = 1'b0;
    logic        outside_reset;
    logic        req_valid, req_ready, req_we, req_unsigned, req_qed_vld;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_read, mem_write, qed_vld_out_ex_mem;
    logic [31:0] address, write_data, read_data;

`ifdef LSU_QED_VLD_EN
    localparam int QED_ON = 1;
`else
    localparam int QED_ON = 0;
`endif

    int vectors = 0;
    int fails   = 0;

    int wr_cnt = 0, rd_cnt = 0, qed_cnt = 0, qed_wr_cnt = 0, qed_stray = 0, both_cnt = 0;
    logic [31:0] last_wd = 32'h0, last_wa = 32'h0;

    logic [31:0] mem [0:31];

    always #5 clk = ~clk;

    lsu_mem_initiator dut (
        .clk                (clk),
        .outside_reset      (outside_reset),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_we             (req_we),
        .req_size           (req_size),
        .req_unsigned       (req_unsigned),
        .req_addr           (req_addr),
        .req_wdata          (req_wdata),
        .req_qed_vld        (req_qed_vld),
        .rsp_valid          (rsp_valid),
        .rsp_ready          (rsp_ready),
        .rsp_rdata          (rsp_rdata),
        .rsp_err            (rsp_err),
        .mem_read           (mem_read),
        .mem_write          (mem_write),
        .address            (address),
        .write_data         (write_data),
        .read_data          (read_data),
        .qed_vld_out_ex_mem (qed_vld_out_ex_mem)
    );

    // data_memory model: level-triggered word read, word write on the clock edge
    assign read_data = mem_read ? mem[address[6:2]] : 32'h0;
    always @(posedge clk) begin
        if (mem_write) mem[address[6:2]] <= write_data;
    end

    // Bus activity monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (mem_write) begin
            wr_cnt  <= wr_cnt + 1;
            last_wd <= write_data;
            last_wa <= address;
        end
        if (mem_read) rd_cnt <= rd_cnt + 1;
        if (qed_vld_out_ex_mem) begin
            qed_cnt <= qed_cnt + 1;
            if (mem_write) qed_wr_cnt <= qed_wr_cnt + 1;
            if (!mem_write && !mem_read) qed_stray <= qed_stray + 1;
        end
        if (mem_read && mem_write) both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one request, wait for the accept edge, then count cycles to rsp_valid
    task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic qed, output int lat);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; req_qed_vld = qed;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic finish_rsp(input string tag);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_idle"}, {30'h0, rsp_valid, req_ready}, 32'h1);
    endtask

    task automatic do_load(input string tag, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic qed, input logic [31:0] exp);
        int lat, rd0, wr0, q0;
        rd0 = rd_cnt; wr0 = wr_cnt; q0 = qed_cnt;
        run_req(1'b0, size, uns, addr, 32'h0, qed, lat);
        chk({tag, "_lat"}, lat, 32'd3);
        chk({tag, "_rdata"}, rsp_rdata, exp);
        chk({tag, "_err"}, {31'h0, rsp_err}, 32'h0);
        finish_rsp(tag);
        chk({tag, "_rd_cycles"}, rd_cnt - rd0, 32'd2);
        chk({tag, "_no_wr"}, wr_cnt - wr0, 32'd0);
        chk({tag, "_qed"}, qed_cnt - q0, (qed && QED_ON == 1) ? 32'd1 : 32'd0);
    endtask

    task automatic do_store(input string tag, input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic qed, input int exp_lat,
                            input int exp_rd, input logic [31:0] exp_word);
        int lat, rd0, wr0, q0, qw0;
        rd0 = rd_cnt; wr0 = wr_cnt; q0 = qed_cnt; qw0 = qed_wr_cnt;
        run_req(1'b1, size, 1'b0, addr, wdata, qed, lat);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_rdata"}, rsp_rdata, 32'h0);
        chk({tag, "_err"}, {31'h0, rsp_err}, 32'h0);
        finish_rsp(tag);
        chk({tag, "_wr_cycles"}, wr_cnt - wr0, 32'd1);
        chk({tag, "_rd_cycles"}, rd_cnt - rd0, exp_rd);
        chk({tag, "_wdata"}, last_wd, exp_word);
        chk({tag, "_waddr"}, last_wa, {addr[31:2], 2'b00});
        chk({tag, "_mem"}, mem[addr[6:2]], exp_word);
        chk({tag, "_qed"}, qed_cnt - q0, (qed && QED_ON == 1) ? 32'd1 : 32'd0);
        chk({tag, "_qed_in_wr"}, qed_wr_cnt - qw0, qed_cnt - q0);
    endtask

    task automatic do_err(input string tag, input logic we, input logic [1:0] size,
                          input logic [31:0] addr);
        int lat, rd0, wr0, q0;
        rd0 = rd_cnt; wr0 = wr_cnt; q0 = qed_cnt;
        run_req(we, size, 1'b0, addr, 32'hCAFE_F00D, 1'b1, lat);
        chk({tag, "_lat"}, lat, 32'd1);
        chk({tag, "_err"}, {31'h0, rsp_err}, 32'h1);
        chk({tag, "_rdata"}, rsp_rdata, 32'h0);
        finish_rsp(tag);
        chk({tag, "_no_bus"}, (rd_cnt - rd0) + (wr_cnt - wr0), 32'd0);
        chk({tag, "_qed"}, qed_cnt - q0, 32'd0);
    endtask

    initial begin : main
        int lat, wr0;
        outside_reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; req_qed_vld = 1'b0; rsp_ready = 1'b1;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        mem[2] = 32'h80FF7F01;
        mem[4] = 32'h11223344;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctl", {26'h0, req_ready, rsp_valid, rsp_err, mem_read, mem_write,
                          qed_vld_out_ex_mem}, 32'h20);
        chk("reset_data", rsp_rdata | address | write_data, 32'h0);
        outside_reset = 1'b0;
        @(posedge clk); #1;

        // Reset while a sub-word store is in RD
        wr0 = wr_cnt;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h10;
        req_wdata = 32'h55; req_qed_vld = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("mid_rd_read", {31'h0, mem_read}, 32'h1);
        outside_reset = 1'b1;
        #1;
        chk("mid_rd_rst_ctl", {26'h0, req_ready, rsp_valid, rsp_err, mem_read, mem_write,
                               qed_vld_out_ex_mem}, 32'h20);
        chk("mid_rd_rst_data", rsp_rdata | address | write_data, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        outside_reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_rd_mem", mem[4], 32'h11223344);
        chk("mid_rd_no_wr", wr_cnt - wr0, 32'd0);
        chk("mid_rd_ready", {31'h0, req_ready}, 32'h1);

        // Word round trip
        do_store("sw44", 2'b10, 32'h44, 32'hDEADBEEF, 1'b1, 2, 0, 32'hDEADBEEF);
        do_load("lw44", 2'b10, 1'b0, 32'h44, 1'b1, 32'hDEADBEEF);

        // Byte / halfword extension on 0x80FF7F01
        do_load("lb0a",  2'b00, 1'b0, 32'h0A, 1'b0, 32'hFFFFFFFF);
        do_load("lbu0a", 2'b00, 1'b1, 32'h0A, 1'b0, 32'h000000FF);
        do_load("lh08",  2'b01, 1'b0, 32'h08, 1'b0, 32'h00007F01);
        do_load("lh0a",  2'b01, 1'b0, 32'h0A, 1'b0, 32'hFFFF80FF);
        do_load("lb09",  2'b00, 1'b0, 32'h09, 1'b0, 32'h0000007F);

        // Sub-word read-modify-write stores on 0x11223344
        do_store("sb11", 2'b00, 32'h11, 32'hFFFF_FFAA, 1'b1, 4, 2, 32'h1122AA44);
        do_store("sh12", 2'b01, 32'h12, 32'h1234_BEEF, 1'b0, 4, 2, 32'hBEEFAA44);
        do_load("lhu12", 2'b01, 1'b1, 32'h12, 1'b0, 32'h0000BEEF);
        do_load("lh12",  2'b01, 1'b0, 32'h12, 1'b0, 32'hFFFFBEEF);

        // Misaligned and illegal requests
        do_err("lw06",  1'b0, 2'b10, 32'h06);
        do_err("sh03",  1'b1, 2'b01, 32'h03);
        do_err("size3", 1'b0, 2'b11, 32'h00);

        // Backpressure on a word load
        rsp_ready = 1'b0;
        run_req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 1'b0, lat);
        chk("bp_lat", lat, 32'd3);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_ctl", {30'h0, rsp_valid, req_ready}, 32'h2);
            chk("bp_hold_data", rsp_rdata, 32'h80FF7F01);
        end
        finish_rsp("bp");

        chk("never_rd_and_wr", both_cnt, 32'd0);
        chk("qed_never_stray", qed_stray, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
